wb_cmd_master: RTL

Byte-stream command decoder and Wishbone classic master that sits directly upstream of `bram` on the shared Wishbone bus. It accepts a framed byte stream from the MCU link deserializer, decodes read/write commands with a 16-bit address, and drives single or burst Wishbone cycles into the memory. Read data returns on a byte response stream.

---
 rtl/wb_cmd_master.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: framed byte-stream command decoder driving a Wishbone
// classic master. Frame = command, addr high, addr low, then one data byte
// per beat for writes. Read beats return one byte on the response stream.
// Define WB_CMD_BURST_EN to honour the length field (1..64 beats with
// address auto-increment); otherwise every frame is a single beat.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_CMD      | waiting for command byte (write flag, length)
// ST_ADDR_HI  | waiting for address high byte
// ST_ADDR_LO  | waiting for address low byte
// ST_WDATA    | waiting for write data byte of the current beat
// ST_BUS      | Wishbone cycle in flight, waiting for ACK or timeout
// ST_RSP      | read byte presented, waiting for consumer to accept
module wb_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  input  logic [7:0]            cmd_data_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_we_o,
  output logic                  wb_cycle_o,
  output logic                  wb_strobe_o,
  input  logic                  wb_ack_i,
  output logic                  timeout_o
);

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WDATA,
    ST_BUS,
    ST_RSP
  } state_t;

  // Wait timer is a down-counter: loaded on entry to ST_BUS, aborts at zero.
  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_n;
  logic                  we_q, we_n;
  logic [7:0]            addr_hi_q, addr_hi_n;
  logic [7:0]            wait_q, wait_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic [DATA_WIDTH-1:0] rsp_data_n;
  logic                  rsp_valid_n;
  logic                  timeout_n;
  logic                  cmd_fire;
  logic                  rsp_fire;
  logic                  last_beat;

`ifdef WB_CMD_BURST_EN
  logic [5:0] beat_q, beat_n;

  assign last_beat = (beat_q == 6'd0);

  // Beats remaining in the current frame.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      beat_q <= 6'd0;
    end else begin
      beat_q <= beat_n;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign rsp_fire = rsp_valid_o && rsp_ready_i;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n     = state_q;
    we_n        = we_q;
    addr_hi_n   = addr_hi_q;
    wait_n      = wait_q;
    addr_n      = wb_addr_o;
    data_n      = wb_data_o;
    rsp_data_n  = rsp_data_o;
    rsp_valid_n = rsp_valid_o;
    timeout_n   = timeout_o;
`ifdef WB_CMD_BURST_EN
    beat_n      = beat_q;
`endif

    case (state_q)
      ST_CMD: begin
        if (cmd_fire) begin
          we_n    = cmd_data_i[7];
`ifdef WB_CMD_BURST_EN
          beat_n  = cmd_data_i[5:0];
`endif
          state_n = ST_ADDR_HI;
        end
      end

      ST_ADDR_HI: begin
        if (cmd_fire) begin
          addr_hi_n = cmd_data_i;
          state_n   = ST_ADDR_LO;
        end
      end

      ST_ADDR_LO: begin
        if (cmd_fire) begin
          addr_n = ADDR_WIDTH'({addr_hi_q, cmd_data_i});
          if (we_q) begin
            state_n = ST_WDATA;
          end else begin
            wait_n  = WAIT_LOAD;
            state_n = ST_BUS;
          end
        end
      end

      ST_WDATA: begin
        if (cmd_fire) begin
          data_n  = cmd_data_i;
          wait_n  = WAIT_LOAD;
          state_n = ST_BUS;
        end
      end

      ST_BUS: begin
        if (wb_ack_i || (wait_q == 8'd0)) begin
          // ACK wins over a simultaneous expiry; a missed ACK still ends the beat.
          if (!wb_ack_i) begin
            timeout_n = 1'b1;
          end
          if (we_q) begin
            if (last_beat) begin
              state_n = ST_CMD;
            end else begin
              state_n = ST_WDATA;
`ifdef WB_CMD_BURST_EN
              beat_n  = beat_q - 6'd1;
              addr_n  = wb_addr_o + ADDR_WIDTH'(1);
`endif
            end
          end else begin
            rsp_data_n  = wb_ack_i ? wb_data_i : {DATA_WIDTH{1'b1}};
            rsp_valid_n = 1'b1;
            state_n     = ST_RSP;
          end
        end else begin
          wait_n = wait_q - 8'd1;
        end
      end

      ST_RSP: begin
        if (rsp_fire) begin
          rsp_valid_n = 1'b0;
          if (last_beat) begin
            state_n = ST_CMD;
          end else begin
            wait_n  = WAIT_LOAD;
            state_n = ST_BUS;
`ifdef WB_CMD_BURST_EN
            beat_n  = beat_q - 6'd1;
            addr_n  = wb_addr_o + ADDR_WIDTH'(1);
`endif
          end
        end
      end

      default: begin
        state_n = ST_CMD;
      end
    endcase
  end

  // State and registered outputs; bus strobes follow the next state directly.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state_q     <= ST_CMD;
      we_q        <= 1'b0;
      addr_hi_q   <= 8'd0;
      wait_q      <= 8'd0;
      cmd_ready_o <= 1'b1;
      rsp_data_o  <= '0;
      rsp_valid_o <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_we_o     <= 1'b0;
      wb_cycle_o  <= 1'b0;
      wb_strobe_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state_q     <= state_n;
      we_q        <= we_n;
      addr_hi_q   <= addr_hi_n;
      wait_q      <= wait_n;
      cmd_ready_o <= (state_n != ST_BUS) && (state_n != ST_RSP);
      rsp_data_o  <= rsp_data_n;
      rsp_valid_o <= rsp_valid_n;
      wb_addr_o   <= addr_n;
      wb_data_o   <= data_n;
      wb_we_o     <= (state_n == ST_BUS) && we_n;
      wb_cycle_o  <= (state_n == ST_BUS);
      wb_strobe_o <= (state_n == ST_BUS);
      timeout_o   <= timeout_n;
    end
  end

endmodule
